// File: rtl/vga_frame_grabber.sv
// vga_frame_grabber: captures one frame of active VGA pixels into a FIFO that a host drains
// through a four-register bus interface (CTRL / STATUS / DATA / COUNT).
module vga_frame_grabber #(
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               read,
    input  logic               write,
    input  logic [1:0]         address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    input  logic               pix_valid,
    input  logic               de,
    input  logic               vsync,
    output logic               busy,
    output logic               irq
);
    localparam int unsigned   PW        = 3 * COLOR_W;
    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   LW        = AW + 1;
    localparam logic [LW-1:0] FIFO_MAX  = LW'(FIFO_DEPTH);
    localparam logic [23:0]   FRAME_CNT = 24'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitVs  = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    state_bits;

    logic          vsync_q;
    logic [23:0]   pix_count_q;
    logic          overflow_q, underflow_q, short_q, irq_q;
    logic [PW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    logic          ctrl_wr, arm_req, abort_req, irq_clr_req, rd_acc, rd_data;
    logic          arm_ok, flush, frame_start, pix_in, frame_full, short_hit, done_entry;
    logic          fifo_empty, fifo_full, pop, push_ok, ovf_hit, udf_hit;
    logic [23:0]   count_inc;
    logic [PW-1:0] pix_word;
    logic [10:0]   level_ext;
    logic [31:0]   status;
    logic          unused_bits;

    assign ctrl_wr     = chipselect & write & (address == 2'd0);
    assign arm_req     = ctrl_wr & writedata[0];
    assign abort_req   = ctrl_wr & writedata[1];
    assign irq_clr_req = ctrl_wr & writedata[2];
    assign rd_acc      = chipselect & read;
    assign rd_data     = rd_acc & (address == 2'd2);

    // Abort beats arm; arm only takes effect from IDLE or DONE.
    assign arm_ok      = arm_req & ~abort_req & ((state_q == StIdle) | (state_q == StDone));
    assign flush       = abort_req | arm_ok;

    assign frame_start = vsync_q & ~vsync;
    assign pix_in      = (state_q == StCapture) & pix_valid & de & ~abort_req;
    assign count_inc   = pix_count_q + 24'd1;
    assign frame_full  = pix_in & (count_inc == FRAME_CNT);
    // A pixel that completes the frame takes precedence over a coincident vsync fall.
    assign short_hit   = (state_q == StCapture) & ~abort_req & frame_start & ~frame_full;
    assign done_entry  = frame_full | short_hit;

    assign fifo_empty  = (level_q == '0);
    assign fifo_full   = (level_q == FIFO_MAX);
    assign pop         = rd_data & ~fifo_empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok     = pix_in & ~flush & (~fifo_full | pop);
    assign ovf_hit     = pix_in & fifo_full & ~pop;
    assign udf_hit     = rd_data & fifo_empty & ~flush;

    assign pix_word    = {pix_r, pix_g, pix_b};
    assign level_ext   = 11'(level_q);
    assign status      = {14'd0, level_ext[9:0], underflow_q, irq_q, short_q, overflow_q,
                          fifo_full, fifo_empty, state_bits};
    assign irq         = irq_q;
    assign unused_bits = ^{writedata[31:3], level_ext[10]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort_req) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (arm_req)     state_d = StWaitVs;
                StWaitVs:       if (frame_start) state_d = StCapture;
                StCapture:      if (done_entry)  state_d = StDone;
                default:        state_d = StIdle;
            endcase
        end
    end

    // State-derived outputs.
    always_comb begin
        state_bits = state_q;
        busy       = (state_q == StWaitVs) | (state_q == StCapture);
    end

    // Capture datapath: vsync history, FIFO pointers/level, pixel count and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pix_count_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            short_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            vsync_q <= vsync;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push_ok && !pop)      level_q <= level_q + LW'(1);
                else if (!push_ok && pop) level_q <= level_q - LW'(1);
            end

            if (arm_ok) begin
                pix_count_q <= '0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
                short_q     <= 1'b0;
            end else begin
                if (pix_in)    pix_count_q <= count_inc;
                if (ovf_hit)   overflow_q  <= 1'b1;
                if (udf_hit)   underflow_q <= 1'b1;
                if (short_hit) short_q     <= 1'b1;
            end

            if (abort_req || arm_ok) irq_q <= 1'b0;
            else if (done_entry)     irq_q <= 1'b1;
            else if (irq_clr_req)    irq_q <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= pix_word;
    end

    // Registered read port: one cycle latency, held between accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_acc) begin
            case (address)
                2'd0: readdata <= '0;
                2'd1: readdata <= status;
                2'd2: readdata <= pop ? 32'(mem_q[rd_ptr_q]) : 32'd0;
                2'd3: readdata <= {8'd0, pix_count_q};
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_grabber.sv
// Bench for vga_frame_grabber: two instances (deep FIFO / shallow FIFO) share one stimulus
// stream; directed table + hand sequences, then random traffic against a behavioural model.
module tb_vga_frame_grabber;
    localparam int unsigned DEPTH_A     = 16;
    localparam int unsigned FRAME_A     = 8;
    localparam int unsigned DEPTH_B     = 4;
    localparam int unsigned FRAME_B     = 6;
    localparam int unsigned RAND_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        reset, cs, rd, wr, pv, de, vs;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [23:0] pix;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, irq_a, irq_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_frame_grabber #(.COLOR_W(8), .FIFO_DEPTH(DEPTH_A), .FRAME_PIXELS(FRAME_A)) dut_a (
        .clk(clk), .reset(reset), .chipselect(cs), .read(rd), .write(wr), .address(addr),
        .writedata(wd), .readdata(rdata_a), .pix_r(pix[23:16]), .pix_g(pix[15:8]),
        .pix_b(pix[7:0]), .pix_valid(pv), .de(de), .vsync(vs), .busy(busy_a), .irq(irq_a)
    );

    vga_frame_grabber #(.COLOR_W(8), .FIFO_DEPTH(DEPTH_B), .FRAME_PIXELS(FRAME_B)) dut_b (
        .clk(clk), .reset(reset), .chipselect(cs), .read(rd), .write(wr), .address(addr),
        .writedata(wd), .readdata(rdata_b), .pix_r(pix[23:16]), .pix_g(pix[15:8]),
        .pix_b(pix[7:0]), .pix_valid(pv), .de(de), .vsync(vs), .busy(busy_b), .irq(irq_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Drive one cycle of inputs, then wait to the next falling edge.
    task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic v, input logic p, input logic e, input logic [23:0] px);
        cs = r | w; rd = r; wr = w; addr = a; wd = d; vs = v; pv = p; de = e; pix = px;
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic v);
        step(1'b1, 1'b0, a, 32'd0, v, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic wr_ctrl(input logic [31:0] d, input logic v);
        step(1'b0, 1'b1, 2'd0, d, v, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic pixel(input logic [23:0] px);
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, px);
    endtask

    task automatic do_reset(input logic v);
        cs = 0; rd = 0; wr = 0; addr = 0; wd = 0; pv = 0; de = 0; pix = 0; vs = v;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_rd", rdata_a, 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_irq", 32'(irq_a), 32'd0);
    endtask

    // Arm, then a vsync fall on the next cycle starts the capture.
    task automatic start_capture();
        wr_ctrl(32'd1, 1'b1);
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    // ---------------- directed vector table (instance A: depth 16, frame 8) ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        vs;
        logic        pv;
        logic        de;
        logic [23:0] pix;
        logic [31:0] exp_rd;
        logic        exp_busy;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [40];
    int   ntbl = 0;

    task automatic add(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic v, input logic p, input logic e, input logic [23:0] px,
                       input logic [31:0] erd, input logic eb, input logic ei);
        tbl[ntbl].rd = r;       tbl[ntbl].wr = w;       tbl[ntbl].addr = a;
        tbl[ntbl].wd = d;       tbl[ntbl].vs = v;       tbl[ntbl].pv = p;
        tbl[ntbl].de = e;       tbl[ntbl].pix = px;     tbl[ntbl].exp_rd = erd;
        tbl[ntbl].exp_busy = eb; tbl[ntbl].exp_irq = ei;
        ntbl++;
    endtask

    // ---------------- behavioural reference model (index 0 = A, 1 = B) ----------------
    int          m_depth [2];
    int          m_frame [2];
    int          ms      [2];   // 0 idle, 1 waiting for vsync, 2 capturing, 3 done
    int          ml      [2];
    int          mcnt    [2];
    bit          movf [2], mudf [2], mshort [2], mirq [2], mvsq [2];
    logic [23:0] mf      [2][16];
    logic [31:0] mrd     [2];

    task automatic model_reset(input int i, input int depth, input int frame);
        m_depth[i] = depth; m_frame[i] = frame;
        ms[i] = 0; ml[i] = 0; mcnt[i] = 0; mrd[i] = 0;
        movf[i] = 0; mudf[i] = 0; mshort[i] = 0; mirq[i] = 0; mvsq[i] = 1;
    endtask

    task automatic model_step(input int i);
        bit          ctrl, arm, abort, iclr, fs, arm_ok, flush, pix_ok, done, data_rd;
        logic [31:0] st;
        ctrl    = cs && wr && addr == 2'd0;
        arm     = ctrl && wd[0];
        abort   = ctrl && wd[1];
        iclr    = ctrl && wd[2];
        fs      = mvsq[i] && !vs;
        arm_ok  = arm && !abort && (ms[i] == 0 || ms[i] == 3);
        flush   = abort || arm_ok;
        data_rd = cs && rd && addr == 2'd2;
        st = 32'(ms[i]) | (ml[i] == 0 ? 32'h4 : 0) | (ml[i] == m_depth[i] ? 32'h8 : 0)
           | (movf[i] ? 32'h10 : 0) | (mshort[i] ? 32'h20 : 0) | (mirq[i] ? 32'h40 : 0)
           | (mudf[i] ? 32'h80 : 0) | (32'(ml[i]) << 8);
        if (cs && rd) begin
            case (addr)
                2'd0: mrd[i] = 0;
                2'd1: mrd[i] = st;
                2'd2: mrd[i] = (flush || ml[i] == 0) ? 32'd0 : 32'(mf[i][0]);
                2'd3: mrd[i] = 32'(mcnt[i]);
            endcase
        end
        if (data_rd && !flush) begin
            if (ml[i] == 0) mudf[i] = 1;
            else begin
                for (int j = 0; j < 15; j++) mf[i][j] = mf[i][j+1];
                ml[i]--;
            end
        end
        pix_ok = ms[i] == 2 && pv && de && !abort;
        done   = 0;
        if (pix_ok) begin
            mcnt[i]++;
            if (ml[i] < m_depth[i]) begin
                mf[i][ml[i]] = pix;
                ml[i]++;
            end else movf[i] = 1;
            if (mcnt[i] == m_frame[i]) done = 1;
        end
        if (ms[i] == 2 && !abort && fs && !done) begin
            mshort[i] = 1;
            done = 1;
        end
        if (abort) begin
            ms[i] = 0; ml[i] = 0; mirq[i] = 0;
        end else if (arm_ok) begin
            ms[i] = 1; ml[i] = 0; mcnt[i] = 0; mirq[i] = 0;
            movf[i] = 0; mudf[i] = 0; mshort[i] = 0;
        end else begin
            if (ms[i] == 1 && fs) ms[i] = 2;
            else if (done) begin
                ms[i] = 3; mirq[i] = 1;
            end
            if (!done && iclr) mirq[i] = 0;
        end
        mvsq[i] = vs;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        do_reset(1'b1);

        // Full frame, gated pixels, arm ignored mid-capture, drain, irq clear, underflow.
        add(1, 0, 1, 0, 1, 0, 0, 0,        32'h04, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0,        32'h04, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0,        32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'hAAAAAA, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h010203, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 24'hBBBBBB, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 24'hCCCCCC, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h020304, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h030405, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h040506, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h050607, 32'h04, 1, 0);
        add(0, 1, 0, 1, 0, 1, 1, 24'h060708, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h070809, 32'h04, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 24'h08090A, 32'h04, 0, 1);
        add(1, 0, 1, 0, 1, 0, 0, 0,        32'h843, 0, 1);
        add(1, 0, 3, 0, 1, 0, 0, 0,        32'd8, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h010203, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h020304, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h030405, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h040506, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h050607, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h060708, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h070809, 0, 1);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h08090A, 0, 1);
        add(1, 0, 1, 0, 1, 0, 0, 0,        32'h47, 0, 1);
        add(0, 1, 0, 4, 1, 0, 0, 0,        32'h47, 0, 0);
        add(1, 0, 2, 0, 1, 0, 0, 0,        32'h0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 0,        32'h87, 0, 0);
        add(0, 1, 0, 3, 1, 0, 0, 0,        32'h87, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 0,        32'h84, 0, 0);

        for (int k = 0; k < ntbl; k++) begin
            step(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].vs, tbl[k].pv, tbl[k].de,
                 tbl[k].pix);
            check($sformatf("vec%0d_rd", k), rdata_a, tbl[k].exp_rd);
            check($sformatf("vec%0d_busy", k), 32'(busy_a), 32'(tbl[k].exp_busy));
            check($sformatf("vec%0d_irq", k), 32'(irq_a), 32'(tbl[k].exp_irq));
        end

        // Overflow on the shallow instance: 6 pixels, no reads, only the first 4 kept.
        do_reset(1'b1);
        start_capture();
        for (int k = 1; k <= 6; k++) pixel(24'h100000 + 24'(k));
        check("ovf_busy", 32'(busy_b), 32'd0);
        check("ovf_irq", 32'(irq_b), 32'd1);
        rd_reg(2'd1, 1'b1);
        check("ovf_status", rdata_b, 32'h45B);
        rd_reg(2'd3, 1'b1);
        check("ovf_count", rdata_b, 32'd6);
        rd_reg(2'd2, 1'b1);
        check("ovf_data0", rdata_b, 32'h100001);
        rd_reg(2'd2, 1'b1);
        rd_reg(2'd2, 1'b1);
        rd_reg(2'd2, 1'b1);
        check("ovf_data3", rdata_b, 32'h100004);
        rd_reg(2'd2, 1'b1);
        check("ovf_drained", rdata_b, 32'd0);

        // Push and pop on a full shallow FIFO in the same cycle.
        do_reset(1'b1);
        start_capture();
        for (int k = 1; k <= 4; k++) pixel(24'h200000 + 24'(k));
        step(1'b1, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1, 1'b1, 24'h200005);
        check("pp_data", rdata_b, 32'h200001);
        rd_reg(2'd1, 1'b0);
        check("pp_status", rdata_b, 32'h40A);
        rd_reg(2'd3, 1'b0);
        check("pp_count", rdata_b, 32'd5);

        // Short frame on the deep instance: second vsync fall after 5 pixels.
        do_reset(1'b1);
        start_capture();
        for (int k = 1; k <= 5; k++) pixel(24'h300000 + 24'(k));
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 24'd0);
        check("short_busy_pre", 32'(busy_a), 32'd1);
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 24'd0);
        check("short_busy", 32'(busy_a), 32'd0);
        check("short_irq", 32'(irq_a), 32'd1);
        rd_reg(2'd1, 1'b0);
        check("short_status", rdata_a, 32'h563);
        rd_reg(2'd3, 1'b0);
        check("short_count", rdata_a, 32'd5);

        // Reset in the middle of a capture discards everything.
        do_reset(1'b1);
        start_capture();
        for (int k = 1; k <= 3; k++) pixel(24'h400000 + 24'(k));
        do_reset(1'b0);
        rd_reg(2'd1, 1'b0);
        check("rstcap_status", rdata_a, 32'h04);
        rd_reg(2'd3, 1'b0);
        check("rstcap_count", rdata_a, 32'd0);
        check("rstcap_irq", 32'(irq_a), 32'd0);

        // vsync held low through reset must not count as a frame start.
        do_reset(1'b0);
        wr_ctrl(32'd1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, 24'h123456);
        rd_reg(2'd1, 1'b0);
        check("vslow_status", rdata_a, 32'h05);
        rd_reg(2'd3, 1'b0);
        check("vslow_count", rdata_a, 32'd0);

        // Random traffic against the model.
        do_reset(1'b1);
        model_reset(0, DEPTH_A, FRAME_A);
        model_reset(1, DEPTH_B, FRAME_B);
        for (int c = 0; c < RAND_CYCLES; c++) begin
            r = $urandom_range(0, 99);
            cs = 0; rd = 0; wr = 0; addr = 0; wd = $urandom;
            if (r < 60) begin
            end else if (r < 78) begin
                cs = 1; rd = 1; addr = 2'd2;
            end else if (r < 86) begin
                cs = 1; rd = 1; addr = 2'd1;
            end else if (r < 89) begin
                cs = 1; rd = 1; addr = 2'd3;
            end else if (r < 94) begin
                cs = 1; wr = 1; wd[0] = 1'b1; wd[1] = 1'b0;
            end else if (r < 95) begin
                cs = 1; wr = 1; wd[1] = 1'b1;
            end else if (r < 97) begin
                cs = 1; wr = 1; wd[1:0] = 2'b00; wd[2] = 1'b1;
            end else if (r < 98) begin
                cs = 1; wr = 1; addr = 2'($urandom_range(1, 3));
            end else begin
                rd = 1'($urandom_range(0, 1)); wr = ~rd; addr = 2'($urandom_range(0, 3));
                wd[0] = 1'b1;
            end
            if (vs) vs = ($urandom_range(0, 99) >= 4);
            else    vs = ($urandom_range(0, 99) < 30);
            pv  = ($urandom_range(0, 99) < 60);
            de  = ($urandom_range(0, 99) < 85);
            pix = 24'($urandom);
            model_step(0);
            model_step(1);
            @(negedge clk);
            check($sformatf("rnd_a_rd@%0d", c), rdata_a, mrd[0]);
            check($sformatf("rnd_a_busy@%0d", c), 32'(busy_a), 32'(ms[0] == 1 || ms[0] == 2));
            check($sformatf("rnd_a_irq@%0d", c), 32'(irq_a), 32'(mirq[0]));
            check($sformatf("rnd_b_rd@%0d", c), rdata_b, mrd[1]);
            check($sformatf("rnd_b_busy@%0d", c), 32'(busy_b), 32'(ms[1] == 1 || ms[1] == 2));
            check($sformatf("rnd_b_irq@%0d", c), 32'(irq_b), 32'(mirq[1]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
